vec_issue_ctrl: RTL and testbench

VEC_ISSUE_CTRL -- requirements
Module: vec_issue_ctrl

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_beat_counter.sv | 25 ++
 rtl/vec_issue_ctrl.sv | 84 ++++++++
 tb/tb_vec_issue_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared states, field positions and default geometry for the vector issue controller
package vec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALAR = 2'd1,
        ST_VECTOR = 2'd2
    } vec_state_e;

    localparam int VEC_BIT   = 31;
    localparam int VLEN_DEF  = 8;
    localparam int LANES_DEF = 2;

    // A single-beat geometry still needs a 1-bit counter to keep port widths legal.
    function automatic int beat_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vec_beat_counter.sv
// rtl/vec_beat_counter.sv - beat counter with consume enable, clear and last-beat detect
module vec_beat_counter #(
    parameter int BEATS = 4,
    parameter int BW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] beat,
    output logic          last
);

    assign last = (beat == BW'(BEATS - 1));

    // Wrapping to zero after the final beat keeps the next instruction starting at element 0.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat <= '0;
        end else if (en) begin
            beat <= last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// rtl/vec_issue_ctrl.sv - issues scalar instructions as one beat and vector instructions as VLEN/LANES beats
module vec_issue_ctrl
    import vec_pkg::*;
#(
    parameter int VLEN  = VLEN_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [31:0]             instr,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    stall_ex,
    output logic                    out_valid,
    output logic [31:0]             out_instr,
    output logic [$clog2(VLEN)-1:0] out_elem,
    output logic                    out_last,
    output logic                    busy
);

    localparam int BEATS  = VLEN / LANES;
    localparam int BW     = beat_width(BEATS);
    localparam int ELEM_W = $clog2(VLEN);

    vec_state_e          state;
    vec_state_e          state_next;
    logic [BW-1:0]       beat;
    logic                beat_last;
    logic                accept;
    logic                consume;
    logic [ELEM_W-1:0]   elem_calc;

    assign out_valid = (state != ST_IDLE);
    assign busy      = (state == ST_VECTOR);
    assign out_last  = (state == ST_SCALAR) || ((state == ST_VECTOR) && beat_last);
    assign elem_calc = ELEM_W'(beat) * ELEM_W'(LANES);
    assign out_elem  = (state == ST_VECTOR) ? elem_calc : '0;

    // Accepting on the final consumed beat removes the bubble between instructions.
    assign in_ready = !flush && (!out_valid || (out_last && !stall_ex));
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && !stall_ex;

    vec_beat_counter #(
        .BEATS (BEATS),
        .BW    (BW)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush || accept),
        .en   (consume && (state == ST_VECTOR)),
        .beat (beat),
        .last (beat_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = ST_IDLE;
        end else if (accept) begin
            state_next = instr[VEC_BIT] ? ST_VECTOR : ST_SCALAR;
        end else if (consume && out_last) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_instr <= '0;
        end else if (accept) begin
            out_instr <= instr;
        end
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// tb/tb_vec_issue_ctrl.sv - scoreboard bench for vec_issue_ctrl with directed and random stimulus
module tb_vec_issue_ctrl;

    localparam int VLEN  = 8;
    localparam int LANES = 2;
    localparam int NBEAT = VLEN / LANES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        stall_ex = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [$clog2(VLEN)-1:0] out_elem;
    logic        out_last;
    logic        busy;

    vec_issue_ctrl #(.VLEN(VLEN), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .instr     (instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .stall_ex  (stall_ex),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_elem  (out_elem),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          elem;
        bit          last;
        bit          busy;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] model_instr = '0;
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: an accepted word becomes a list of beats; the output always shows the list head.
    int    n;
    bit    exp_ready;
    beat_t h;
    always @(negedge clk) begin
        n = exp_q.size();
        exp_ready = !flush && (n == 0 || (n == 1 && !stall_ex));
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
        check("out_valid", {31'b0, out_valid}, {31'b0, n != 0});
        check("out_instr", out_instr, model_instr);
        if (n != 0) begin
            h = exp_q[0];
            check("out_elem", 32'(out_elem), 32'(h.elem));
            check("out_last", {31'b0, out_last}, {31'b0, h.last});
            check("busy", {31'b0, busy}, {31'b0, h.busy});
        end else begin
            check("idle_elem", 32'(out_elem), 32'd0);
            check("idle_last", {31'b0, out_last}, 32'd0);
            check("idle_busy", {31'b0, busy}, 32'd0);
        end
        if (rst) begin
            exp_q.delete();
            model_instr = '0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            if (n != 0 && !stall_ex) void'(exp_q.pop_front());
            if (in_valid && exp_ready) begin
                model_instr = instr;
                if (instr[31]) begin
                    for (int k = 0; k < NBEAT; k++)
                        exp_q.push_back('{instr, k * LANES, k == NBEAT - 1, 1'b1});
                end else begin
                    exp_q.push_back('{instr, 0, 1'b1, 1'b0});
                end
            end
        end
    end

    task automatic step(input int cycles = 1);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] word);
        in_valid = 1'b1;
        instr    = word;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_elem(input int e);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (out_valid && busy && 32'(out_elem) == e) found = 1'b1;
            else step();
        end
        if (!found) begin
            total++;
            $display("FAIL wait_elem: element %0d never presented", e);
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        issue(32'h0000_1234);
        step(3);

        issue(32'h8000_0010);
        step(6);

        issue(32'h8000_0020);
        wait_elem(2);
        stall_ex = 1'b1;
        step(3);
        stall_ex = 1'b0;
        step(5);

        issue(32'h8000_0030);
        wait_elem(6);
        issue(32'h0000_0055);
        step(3);

        issue(32'h8000_0040);
        wait_elem(4);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = 32'h8000_00AA;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step(3);

        issue(32'h8000_0050);
        wait_elem(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step(6);

        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            instr    = $urandom();
            stall_ex = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            step();
        end
        in_valid = 1'b0;
        stall_ex = 1'b0;
        flush    = 1'b0;
        rst      = 1'b0;
        step(8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
